// File: rtl/dodge_pkg.sv
// dodge_pkg: board defaults, player sprite, LFSR constants and spawn FSM
// states shared by the dodge game blocks.
package dodge_pkg;

  localparam int BOARD_WIDTH_DEF  = 9;
  localparam int BOARD_HEIGHT_DEF = 16;

  // Player sprite, 3 bits per row; index 0 is the bottom board row.
  localparam logic [3:0][2:0] PLAYER_SPRITE = {3'b010, 3'b111, 3'b010, 3'b101};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    GAP = 2'd0,
    TOP = 2'd1,
    BOT = 2'd2
  } spawn_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/obstacle_logic_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, seeded on reset.
module lfsr16
  import dodge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  // Next LFSR state.
  always_comb begin
    q_d = lfsr_next(q_q);
  end

  // LFSR register; advances every cycle outside reset.
  always_ff @(posedge clk) begin
    if (reset) q_q <= LFSR_SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_logic.sv
// obstacle_logic: scrolls the falling obstacle field one row per game tick,
// spawns 2-row x 3-column blocks at pseudo-random column groups, strobes
// update_board after each scroll, flags player collisions and counts dodges.
// Optional macro OBSTACLE_SPEEDUP_EN shortens the tick period as score grows.
module obstacle_logic
  import dodge_pkg::*;
#(
  parameter int board_width  = BOARD_WIDTH_DEF,
  parameter int board_height = BOARD_HEIGHT_DEF,
  parameter int tick_period  = 12500000,
  parameter int min_gap      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_Over,
  input  logic [4:0]             player_pos,
  output logic [board_width-1:0] obstacle_data [0:board_height-1],
  output logic                   update_board,
  output logic                   hit,
  output logic [15:0]            score
);

  localparam int CW      = $clog2(tick_period);
  localparam int GW      = $clog2(min_gap + 1);
  localparam int NGROUPS = board_width / 3;

  logic [board_width-1:0] rows_q [0:board_height-1];
  logic [board_width-1:0] rows_d [0:board_height-1];
  logic [CW-1:0]          count_q, count_d, last;
  logic                   tick;
  spawn_state_t           state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [board_width-1:0] pattern_q, pattern_d, top_pattern, new_row;
  logic                   update_q, update_d;
  logic                   hit_q, hit_d, overlap;
  logic [15:0]            score_q, score_d;
  logic [15:0]            lfsr_q;
  logic                   lfsr_unused;
  int                     grp;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:8];

`ifdef OBSTACLE_SPEEDUP_EN
  localparam int PW = $clog2(tick_period + 1);
  logic [PW-1:0] period_q, period_d;

  assign last = CW'(period_q - PW'(1));

  // Re-latch the period only on a wrap so a change never cuts a tick short.
  always_comb begin
    period_d = period_q;
    if (tick) begin
      if (score_d >= 16'd64)      period_d = PW'(tick_period >> 2);
      else if (score_d >= 16'd32) period_d = PW'(tick_period >> 1);
      else                        period_d = PW'(tick_period);
    end
  end

  // Effective tick period register.
  always_ff @(posedge clk) begin
    if (reset) period_q <= PW'(tick_period);
    else       period_q <= period_d;
  end
`else
  assign last = CW'(tick_period - 1);
`endif

  assign tick = (count_q == last) && !game_Over;

  // Tick counter: wraps at the period, holds while the game is over.
  always_comb begin
    count_d = count_q;
    if (!game_Over) count_d = (count_q == last) ? '0 : count_q + CW'(1);
  end

  // Spawn FSM: gap rows, then the top and bottom rows of one block.
  always_comb begin
    grp         = int'(lfsr_q[7:0]) % NGROUPS;
    top_pattern = board_width'(3'b111) << (3 * grp);
    state_d     = state_q;
    gap_d       = gap_q;
    pattern_d   = pattern_q;
    new_row     = '0;
    if (tick) begin
      case (state_q)
        GAP: begin
          if (gap_q == GW'(1)) state_d = TOP;
          else                 gap_d   = gap_q - GW'(1);
        end
        TOP: begin
          pattern_d = top_pattern;
          new_row   = top_pattern;
          state_d   = BOT;
        end
        BOT: begin
          new_row = pattern_q;
          gap_d   = GW'(min_gap);
          state_d = GAP;
        end
        default: state_d = GAP;
      endcase
    end
  end

  // Row scroll, dodge scoring and strobe generation.
  always_comb begin
    rows_d   = rows_q;
    score_d  = score_q;
    update_d = tick;
    if (tick) begin
      if (rows_q[board_height-1] != '0 && rows_q[board_height-2] == '0 &&
          score_q != 16'hFFFF)
        score_d = score_q + 16'd1;
      for (int unsigned i = 1; i < board_height; i++) rows_d[i] = rows_q[i-1];
      rows_d[0] = new_row;
    end
  end

  // Sticky collision: sprite rows against the bottom four board rows.
  always_comb begin
    overlap = 1'b0;
    if (int'(player_pos) < NGROUPS) begin
      for (int unsigned r = 0; r < 4; r++) begin
        overlap = overlap |
          (|(rows_q[board_height-1-r] &
             (board_width'(PLAYER_SPRITE[r]) << (3 * int'(player_pos)))));
      end
    end
    hit_d = hit_q | overlap;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q    <= '{default: '0};
      count_q   <= '0;
      state_q   <= GAP;
      gap_q     <= GW'(min_gap);
      pattern_q <= '0;
      update_q  <= 1'b0;
      hit_q     <= 1'b0;
      score_q   <= '0;
    end else begin
      rows_q    <= rows_d;
      count_q   <= count_d;
      state_q   <= state_d;
      gap_q     <= gap_d;
      pattern_q <= pattern_d;
      update_q  <= update_d;
      hit_q     <= hit_d;
      score_q   <= score_d;
    end
  end

  assign obstacle_data = rows_q;
  assign update_board  = update_q;
  assign hit           = hit_q;
  assign score         = score_q;

endmodule

// File: tb/tb_obstacle_logic.sv
// tb_obstacle_logic: directed stimulus with a behavioural reference model
// compared every cycle, plus hand-derived literal expectations.
module tb_obstacle_logic;

  localparam int W  = 9;
  localparam int H  = 16;
  localparam int TP = 4;
  localparam int MG = 3;

  logic         clk;
  logic         reset;
  logic         game_Over;
  logic [4:0]   player_pos;
  logic [W-1:0] obstacle_data [0:H-1];
  logic         update_board;
  logic         hit;
  logic [15:0]  score;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  obstacle_logic #(
    .board_width  (W),
    .board_height (H),
    .tick_period  (TP),
    .min_gap      (MG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .game_Over     (game_Over),
    .player_pos    (player_pos),
    .obstacle_data (obstacle_data),
    .update_board  (update_board),
    .hit           (hit),
    .score         (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_rows [0:H-1];
  logic [W-1:0] m_pat, m_new;
  logic [15:0]  m_lfsr, m_score;
  logic         m_upd, m_hit, m_tick, m_ov;
  int           m_cnt, m_k, m_ph, m_grp;
  int           grp_q [$];
  int           spr [4] = '{5, 2, 7, 2};  // bottom row first

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < H; i++) m_rows[i] = '0;
      m_cnt = 0; m_k = 0; m_upd = 0; m_hit = 0; m_score = 0;
      m_lfsr = 16'hACE1; m_pat = '0;
    end else begin
      m_tick = (m_cnt == TP - 1) && !game_Over;
      m_ov = 0;
      if (player_pos < 3)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 3; c++)
            if (((spr[r] >> c) & 1) == 1 && m_rows[H-1-r][3*player_pos+c] == 1'b1)
              m_ov = 1;
      m_hit = m_hit | m_ov;
      if (m_tick) begin
        m_k++;
        m_ph = (m_k - 1) % (MG + 2);
        if (m_ph == MG) begin
          m_grp = m_lfsr[7:0] % 3;
          m_pat = 9'b111 << (3 * m_grp);
          grp_q.push_back(m_grp);
          m_new = m_pat;
        end else if (m_ph == MG + 1) m_new = m_pat;
        else m_new = '0;
        if (m_rows[H-1] != 0 && m_rows[H-2] == 0 && m_score != 16'hFFFF) m_score++;
        for (int i = H - 1; i > 0; i--) m_rows[i] = m_rows[i-1];
        m_rows[0] = m_new;
      end
      m_upd = m_tick;
      if (!game_Over) m_cnt = (m_cnt == TP - 1) ? 0 : m_cnt + 1;
      m_lfsr = m_next(m_lfsr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic prev_ub = 1'b0;
  int   rdiff;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_update_board", 32'(update_board), 32'(m_upd));
      chk("model_hit", 32'(hit), 32'(m_hit));
      chk("model_score", 32'(score), 32'(m_score));
      rdiff = -1;
      for (int i = 0; i < H; i++)
        if (obstacle_data[i] !== m_rows[i] && rdiff < 0) rdiff = i;
      checks++;
      if (rdiff >= 0) begin
        errors++;
        $display("FAIL model_row%0d actual=%0h required=%0h", rdiff,
                 obstacle_data[rdiff], m_rows[rdiff]);
      end
      checks++;
      if (update_board === 1'b1 && prev_ub === 1'b1) begin
        errors++;
        $display("FAIL strobe_consecutive actual=2 cycles required=1 cycle");
      end
      prev_ub = update_board;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_row();
    logic a;
    a = 1'b0;
    for (int i = 0; i < H; i++) a = a | (|obstacle_data[i]);
    return a;
  endfunction

  task automatic run_ticks(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = 8 * n;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (update_board === 1'b1) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL tick_wait actual=%0d required=%0d", seen, n);
    end
  endtask

  int           g1, g2;
  logic [W-1:0] p1, p2, r0;

  initial begin
    reset = 1'b1; game_Over = 1'b0; player_pos = 5'd31;
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_update_board", 32'(update_board), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_rows", 32'(any_row()), 0);
    reset = 1'b0;

    for (int s = 1; s <= 16; s++) begin
      step();
      if (s == 1) chk("model_lfsr_step1", 32'(m_lfsr), 32'h5670);
      if (s == 2) chk("model_lfsr_step2", 32'(m_lfsr), 32'hAB38);
      chk($sformatf("strobe_cycle%0d", s), 32'(update_board), 32'(s % 4 == 0));
      if (s == 12) chk("rows_zero_after_3_ticks", 32'(any_row()), 0);
    end

    // 4th tick: first block row
    r0 = obstacle_data[0];
    chk("blk_shape", 32'(r0 == 9'h007 || r0 == 9'h038 || r0 == 9'h1C0), 1);
    chk("spawn_recorded", grp_q.size(), 1);
    g1 = (grp_q.size() > 0) ? grp_q[0] : 0;
    p1 = 9'b111 << (3 * g1);
    chk("tick4_row0", 32'(obstacle_data[0]), 32'(p1));
    player_pos = 5'((g1 + 1) % 3);

    repeat (4) step();
    chk("tick5_strobe", 32'(update_board), 1);
    chk("tick5_row0", 32'(obstacle_data[0]), 32'(p1));
    chk("tick5_row1", 32'(obstacle_data[1]), 32'(p1));
    repeat (4) step();
    chk("tick6_row0", 32'(obstacle_data[0]), 0);
    chk("tick6_row2", 32'(obstacle_data[2]), 32'(p1));

    // freeze for 10 cycles with one count already elapsed
    step();
    game_Over = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("freeze_no_strobe", 32'(update_board), 0);
    end
    chk("freeze_row1", 32'(obstacle_data[1]), 32'(p1));
    chk("freeze_row2", 32'(obstacle_data[2]), 32'(p1));
    chk("freeze_score", 32'(score), 0);
    game_Over = 1'b0;
    step(); chk("resume_c1", 32'(update_board), 0);
    step(); chk("resume_c2", 32'(update_board), 0);
    step(); chk("resume_c3", 32'(update_board), 1);
    chk("tick7_row3", 32'(obstacle_data[3]), 32'(p1));

    // first block leaves the board beside the player
    run_ticks(13);
    chk("tick20_row15", 32'(obstacle_data[15]), 32'(p1));
    chk("tick20_score", 32'(score), 0);
    run_ticks(1);
    chk("dodge_score", 32'(score), 1);
    chk("dodge_hit", 32'(hit), 0);

    // second block: move the player under it
    chk("spawn2_recorded", 32'(grp_q.size() >= 2), 1);
    g2 = (grp_q.size() > 1) ? grp_q[1] : 0;
    p2 = 9'b111 << (3 * g2);
    chk("tick21_row12", 32'(obstacle_data[12]), 32'(p2));
    player_pos = 5'(g2);
    chk("hit_before_latency", 32'(hit), 0);
    step();
    chk("hit_after_overlap", 32'(hit), 1);
    run_ticks(2);
    chk("hit_sticky", 32'(hit), 1);

    // reset landing on a tick cycle
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_tick_update_board", 32'(update_board), 0);
    chk("rst_tick_hit", 32'(hit), 0);
    chk("rst_tick_score", 32'(score), 0);
    chk("rst_tick_rows", 32'(any_row()), 0);
    reset = 1'b0;
    run_ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
